// File: rtl/mb_sync_rx.sv
// mb_sync_rx: destination half of a toggle req/ack multibit synchronizer.
// Only the 1-bit req level crosses through the synchronizer chain. The data bus
// is held stable by the source, so it is sampled directly when a req toggle arrives.
// Ports:
//    i_clock   destination clock, rising edge
//    i_reset   asynchronous active-low reset
//    i_data    source word, stable while a request is pending
//    i_req     asynchronous request level, one toggle per word
//    o_data    last captured word
//    o_valid   one-cycle pulse when o_data updates
//    o_ack     last accepted req level, returned to the source
//    i_parity  even parity of i_data (MB_SYNC_PARITY_EN only)
//    o_par_err parity mismatch at last capture (MB_SYNC_PARITY_EN only)
// Optional feature macro: MB_SYNC_PARITY_EN
module mb_sync_rx #(
   parameter int NB          = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic          i_clock,
   input  logic          i_reset,
   input  logic [NB-1:0] i_data,
   input  logic          i_req,
`ifdef MB_SYNC_PARITY_EN
   input  logic          i_parity,
   output logic          o_par_err,
`endif
   output logic [NB-1:0] o_data,
   output logic          o_valid,
   output logic          o_ack
);
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   req_prev_q, req_prev_d;
   logic [NB-1:0]          data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   ack_q, ack_d;
   logic                   req_sync, req_edge;
`ifdef MB_SYNC_PARITY_EN
   logic                   par_err_q, par_err_d;
`endif
   assign req_sync = sync_q[SYNC_STAGES-1];
   // either toggle direction is a new request
   assign req_edge = req_sync ^ req_prev_q;
   always_comb begin
      sync_d     = {sync_q[SYNC_STAGES-2:0], i_req};
      req_prev_d = req_sync;
      data_d     = req_edge ? i_data : data_q;
      valid_d    = req_edge;
      ack_d      = req_edge ? req_sync : ack_q;
`ifdef MB_SYNC_PARITY_EN
      par_err_d  = req_edge ? ((^i_data) != i_parity) : par_err_q;
`endif
   end
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         sync_q     <= '0;
         req_prev_q <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         ack_q      <= 1'b0;
`ifdef MB_SYNC_PARITY_EN
         par_err_q  <= 1'b0;
`endif
      end else begin
         sync_q     <= sync_d;
         req_prev_q <= req_prev_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         ack_q      <= ack_d;
`ifdef MB_SYNC_PARITY_EN
         par_err_q  <= par_err_d;
`endif
      end
   end
   assign o_data  = data_q;
   assign o_valid = valid_q;
   assign o_ack   = ack_q;
`ifdef MB_SYNC_PARITY_EN
   assign o_par_err = par_err_q;
`endif
endmodule

// File: tb/tb_mb_sync_rx.sv
// tb_mb_sync_rx: directed self-checking bench for mb_sync_rx.
module tb_mb_sync_rx;
   logic       i_clock = 1'b0;
   logic       src_clk = 1'b0;
   logic       i_reset = 1'b1;
   logic [7:0] i_data  = 8'hA5;
   logic       i_req   = 1'b0;
   logic [7:0] o_data;
   logic       o_valid;
   logic       o_ack;
`ifdef MB_SYNC_PARITY_EN
   logic       i_parity = 1'b0;
   logic       o_par_err;
`endif
   logic       ack_s1, ack_s2;
   int         n_cmp = 0;
   int         n_err = 0;

   mb_sync_rx #(.NB(8), .SYNC_STAGES(2)) dut (
      .i_clock(i_clock),
      .i_reset(i_reset),
      .i_data(i_data),
      .i_req(i_req),
`ifdef MB_SYNC_PARITY_EN
      .i_parity(i_parity),
      .o_par_err(o_par_err),
`endif
      .o_data(o_data),
      .o_valid(o_valid),
      .o_ack(o_ack)
   );

   always #5 i_clock = ~i_clock;
   always #2 src_clk = ~src_clk;

   always_ff @(posedge src_clk or negedge i_reset) begin
      if (!i_reset) begin
         ack_s1 <= 1'b0;
         ack_s2 <= 1'b0;
      end else begin
         ack_s1 <= o_ack;
         ack_s2 <= ack_s1;
      end
   end

   task automatic step();
      @(posedge i_clock);
      #1;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      for (int c = 1; c <= 8; c++) begin
         step();
         if (o_valid === 1'b1) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #3 i_reset = 1'b0;
      #1;
      n_cmp++;
      if (o_data !== 8'h00 || o_valid !== 1'b0 || o_ack !== 1'b0) begin
         n_err++;
         $display("FAIL reset_async: data=%h valid=%b ack=%b want 00/0/0", o_data, o_valid, o_ack);
      end
      for (int c = 0; c < 3; c++) begin
         step();
         n_cmp++;
         if (o_data !== 8'h00 || o_valid !== 1'b0 || o_ack !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold%0d: data=%h valid=%b ack=%b want 00/0/0", c, o_data, o_valid, o_ack);
         end
      end
      i_reset = 1'b1;
      for (int c = 0; c < 3; c++) step();
   endtask

   task automatic one_word(input string nm, input logic [7:0] d, input logic lvl);
      int lat;
      i_data = d;
      step();
      i_req = lvl;
      wait_valid(lat);
      n_cmp++;
      if (lat < 2 || lat > 4) begin
         n_err++;
         $display("FAIL %s_latency: got %0d cycles want 3 (+-1)", nm, lat);
      end
      n_cmp++;
      if (o_data !== d || o_ack !== lvl) begin
         n_err++;
         $display("FAIL %s_capture: data=%h ack=%b want %h/%b", nm, o_data, o_ack, d, lvl);
      end
      step();
      n_cmp++;
      if (o_valid !== 1'b0) begin
         n_err++;
         $display("FAIL %s_single_pulse: valid=%b want 0", nm, o_valid);
      end
      for (int c = 0; c < 3; c++) step();
   endtask

   task automatic test_single_word();
      one_word("rise", 8'h3C, 1'b1);
   endtask

   task automatic test_falling();
      one_word("fall", 8'hC3, 1'b0);
   endtask

   task automatic test_idle_change();
      int pulses = 0;
      i_data = 8'h11;
      step();
      if (o_valid === 1'b1) pulses++;
      step();
      if (o_valid === 1'b1) pulses++;
      i_data = 8'h22;
      for (int c = 0; c < 6; c++) begin
         step();
         if (o_valid === 1'b1) pulses++;
      end
      n_cmp++;
      if (pulses != 0 || o_data !== 8'hC3) begin
         n_err++;
         $display("FAIL idle_change: pulses=%0d data=%h want 0/c3", pulses, o_data);
      end
   endtask

   task automatic test_handshake();
      logic [7:0] words[20];
      int got = 0;
      bit src_to = 1'b0;
      for (int i = 0; i < 20; i++) words[i] = 8'((i * 37) + 5);
      fork
         begin
            for (int i = 0; i < 20; i++) begin
               int t = 0;
               while (ack_s2 !== i_req && t < 300) begin
                  @(posedge src_clk);
                  t++;
               end
               if (t >= 300) begin
                  src_to = 1'b1;
                  break;
               end
               @(posedge src_clk);
               #1 i_data = words[i];
               @(posedge src_clk);
               #1 i_req = ~i_req;
            end
         end
         begin
            int cyc = 0;
            while (got < 20 && cyc < 1500) begin
               step();
               cyc++;
               if (o_valid === 1'b1) begin
                  n_cmp++;
                  if (o_data !== words[got]) begin
                     n_err++;
                     $display("FAIL hs_word%0d: data=%h want %h", got, o_data, words[got]);
                  end
                  got++;
               end
            end
         end
      join
      for (int c = 0; c < 6; c++) begin
         step();
         if (o_valid === 1'b1) got++;
      end
      n_cmp++;
      if (got != 20 || src_to) begin
         n_err++;
         $display("FAIL hs_count: pulses=%0d src_timeout=%0b want 20/0", got, src_to);
      end
      n_cmp++;
      if (o_ack !== i_req) begin
         n_err++;
         $display("FAIL hs_final_ack: ack=%b want %b", o_ack, i_req);
      end
   endtask

   task automatic test_back_to_back();
      int pulses = 0;
      int consec = 0;
      logic prev = 1'b0;
      i_data = 8'h9E;
      step();
      i_req = ~i_req;
      step();
      i_req = ~i_req;
      for (int c = 0; c < 8; c++) begin
         step();
         if (o_valid === 1'b1) begin
            pulses++;
            if (prev) consec++;
         end
         prev = (o_valid === 1'b1);
      end
      n_cmp++;
      if (pulses != 2 || consec != 1) begin
         n_err++;
         $display("FAIL b2b_pulses: pulses=%0d consecutive=%0d want 2/1", pulses, consec);
      end
      n_cmp++;
      if (o_data !== 8'h9E || o_ack !== i_req) begin
         n_err++;
         $display("FAIL b2b_state: data=%h ack=%b want 9e/%b", o_data, o_ack, i_req);
      end
   endtask

   task automatic test_reset_mid();
      int pulses = 0;
      i_data = 8'h77;
      step();
      i_req = ~i_req;
      step();
      if (o_valid === 1'b1) pulses++;
      i_reset = 1'b0;
      #1;
      n_cmp++;
      if (o_data !== 8'h00 || o_valid !== 1'b0 || o_ack !== 1'b0) begin
         n_err++;
         $display("FAIL mid_reset_clear: data=%h valid=%b ack=%b want 00/0/0", o_data, o_valid, o_ack);
      end
      i_req = 1'b0;
      step();
      step();
      i_reset = 1'b1;
      for (int c = 0; c < 8; c++) begin
         step();
         if (o_valid === 1'b1) pulses++;
      end
      n_cmp++;
      if (pulses != 0 || o_data !== 8'h00 || o_ack !== 1'b0) begin
         n_err++;
         $display("FAIL mid_reset_lost: pulses=%0d data=%h ack=%b want 0/00/0", pulses, o_data, o_ack);
      end
   endtask

   task automatic test_release_with_req();
      int lat;
      i_reset = 1'b0;
      i_req = 1'b1;
      i_data = 8'h5A;
      step();
      i_reset = 1'b1;
      wait_valid(lat);
      n_cmp++;
      if (lat < 2 || lat > 4) begin
         n_err++;
         $display("FAIL release_latency: got %0d cycles want 3 (+-1)", lat);
      end
      n_cmp++;
      if (o_data !== 8'h5A || o_ack !== 1'b1) begin
         n_err++;
         $display("FAIL release_capture: data=%h ack=%b want 5a/1", o_data, o_ack);
      end
      for (int c = 0; c < 3; c++) step();
   endtask

`ifdef MB_SYNC_PARITY_EN
   task automatic test_parity();
      int lat;
      i_data = 8'h07;
      i_parity = 1'b0;
      step();
      i_req = ~i_req;
      wait_valid(lat);
      n_cmp++;
      if (lat == 0 || o_par_err !== 1'b1 || o_data !== 8'h07) begin
         n_err++;
         $display("FAIL parity_bad: lat=%0d par_err=%b data=%h want 1/07", lat, o_par_err, o_data);
      end
      for (int c = 0; c < 3; c++) step();
      i_data = 8'h03;
      i_parity = 1'b0;
      step();
      i_req = ~i_req;
      wait_valid(lat);
      n_cmp++;
      if (lat == 0 || o_par_err !== 1'b0 || o_data !== 8'h03) begin
         n_err++;
         $display("FAIL parity_good: lat=%0d par_err=%b data=%h want 0/03", lat, o_par_err, o_data);
      end
      for (int c = 0; c < 3; c++) step();
   endtask
`endif

   initial begin
      test_reset();
      test_single_word();
      test_falling();
      test_idle_change();
      test_handshake();
      test_back_to_back();
      test_reset_mid();
      test_release_with_req();
`ifdef MB_SYNC_PARITY_EN
      test_parity();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/mb_sync_rx.md
Name: mb_sync_rx

Overview:
- Destination-domain half of a multibit level-handshake (toggle req/ack) synchronizer.
- Source logic in another clock domain does three things per word:
  - places a word on i_data;
  - holds it stable;
  - toggles i_req.
- This block synchronizes i_req, captures the stable bus on each detected toggle, pulses o_valid, and returns o_ack (level) for the source to synchronize back.
- The bus itself is never passed through synchronizer flops; only the 1-bit req level is.

Parameters:
- NB, 8, data bus width in bits (>=1).
- SYNC_STAGES, 2, number of flops in the req synchronizer chain (>=2).

Ports:
- i_clock  input  1  destination clock; all state on rising edge.
- i_reset  input  1  one clock; reset is asynchronous and active-low (i_reset=0 resets).
- i_data  input  NB  source data; guaranteed stable from before the i_req toggle until o_ack matches i_req.
- i_req  input  1  asynchronous request level; one toggle per word.
- o_data  output  NB  last captured word, registered.
- o_valid  output  1  one-cycle pulse, high in the cycle o_data updates.
- o_ack  output  1  acknowledge level, equal to the last accepted req level, registered.

Behaviour:
- Reset (i_reset=0, asynchronous assert; deassert sampled synchronously by the user's reset tree) forces these to 0:
  - sync chain, req_prev, o_data, o_valid, o_ack.
- Sync chain:
  - s[0] <= i_req; s[k] <= s[k-1]; req_sync = s[SYNC_STAGES-1].
  - req_prev <= req_sync every cycle.
- Edge detect: req_edge = req_sync XOR req_prev (combinational). Both rising and falling toggles are requests.
- On req_edge=1 at a rising clock edge, all of the following happen at that edge:
  - o_data <= i_data;
  - o_valid <= 1;
  - o_ack <= req_sync.
- Otherwise:
  - o_valid <= 0;
  - o_data and o_ack hold.
- Latency: i_req toggles before edge T0 with setup met. Then:
  - req_sync changes after edge T0+SYNC_STAGES-1;
  - o_data, o_valid and o_ack update after edge T0+SYNC_STAGES (3 cycles for default).
- A metastable first stage may add one cycle; the bench must tolerate ±1 cycle.
- Throughput: the next word is accepted only after the source sees o_ack toggle. Back-to-back req toggles in consecutive destination cycles are still each captured; no internal queue exists.
- The source must not toggle i_req again while i_req != o_ack. If it does, data integrity is not guaranteed, but the block never locks up: every edge at req_sync produces exactly one o_valid.
- i_data changes while no request is pending are ignored; o_data holds.
- Reset mid-transfer:
  - all state clears and the pending request is lost;
  - if i_req=1 at reset release, it is seen as a fresh request SYNC_STAGES+1 cycles later. The source must reset together with this block.
- o_valid is never high for two consecutive cycles unless req_sync toggled in two consecutive cycles.

Optional Feature:
- MB_SYNC_PARITY_EN.
- When defined:
  - adds input i_parity (1 bit, even parity of i_data, held with i_data);
  - adds output o_par_err (1 bit, registered, reset 0).
- At each capture, o_par_err <= (^i_data) != i_parity; it is held until the next capture. o_data is captured regardless.
- When undefined: neither port exists and no parity logic is generated.

Test Plan:
- Reset: i_reset=0 with i_req=0 and i_data=8'hA5 -> o_data=0, o_valid=0 and o_ack=0 immediately (asynchronous), held until release.
- Single word: after reset, i_data=8'h3C, toggle i_req 0->1 -> exactly one o_valid pulse 3 cycles later (±1), o_data=8'h3C, o_ack=1.
- Falling toggle: i_data=8'hC3, i_req 1->0 -> one o_valid pulse, o_data=8'hC3, o_ack=0.
- Full handshake with asynchronous source: src clk period 4, dest period 10, 20 words via i_req toggles and o_ack sync-back on the src side -> 20 o_valid pulses, o_data matching each word in order.
- Idle data change: i_data changes 8'h11->8'h22 with no i_req toggle -> no o_valid, o_data unchanged.
- Reset mid-transfer: toggle i_req, assert i_reset one cycle later -> no o_valid; outputs 0. With MB_SYNC_PARITY_EN, a capture with a wrong i_parity -> o_par_err=1.
